// File: rtl/cmip_req_dispatch.sv
// cmip_req_dispatch: per-channel command FIFOs feeding a round-robin scheduler, one registered output slot
// Ports: i_clk/i_rst (async active-high); i_ch_vld/i_ch_data/o_ch_rdy per-channel ingress;
//   o_sch_req/o_sch_rdy to scheduler, i_gnt_vld/i_gnt_idx grant back (same cycle);
//   o_vld/o_data/o_ch_idx/i_rdy downstream handshake; o_err sticky illegal-grant flag.
// Optional: define CMIP_DISP_ERR_CHK_EN to enable the o_err illegal-grant detector.
module cmip_req_dispatch #(
  parameter int CH_NUM     = 8,
  parameter int IDX_WDTH   = 3,
  parameter int DATA_WDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WDTH   = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [CH_NUM-1:0]             i_ch_vld,
  input  logic [CH_NUM*DATA_WDTH-1:0]   i_ch_data,
  output logic [CH_NUM-1:0]             o_ch_rdy,
  output logic [CH_NUM-1:0]             o_sch_req,
  output logic                          o_sch_rdy,
  input  logic                          i_gnt_vld,
  input  logic [IDX_WDTH-1:0]           i_gnt_idx,
  output logic                          o_vld,
  output logic [DATA_WDTH-1:0]          o_data,
  output logic [IDX_WDTH-1:0]           o_ch_idx,
  input  logic                          i_rdy,
  output logic                          o_err
);
  logic [CH_NUM-1:0]           push, pop;
  logic [CH_NUM*DATA_WDTH-1:0] head;
  logic                        idx_ok, legal;
  logic                        vld_q, vld_d;
  logic [DATA_WDTH-1:0]        data_q, data_d;
  logic [IDX_WDTH-1:0]         idx_q, idx_d;
  // widened compare keeps the range check meaningful when CH_NUM == 2**IDX_WDTH
  assign idx_ok    = {1'b0, i_gnt_idx} < (IDX_WDTH+1)'(CH_NUM);
  assign o_sch_rdy = ~vld_q | i_rdy;
  assign legal     = i_gnt_vld & o_sch_rdy & idx_ok & o_sch_req[i_gnt_idx];
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [PTR_WDTH:0]    cnt_q, cnt_d;
    logic [PTR_WDTH-1:0]  wp_q, rp_q;
    logic [DATA_WDTH-1:0] mem_q [FIFO_DEPTH];
    // ready/request come from registered count only, so a full FIFO refuses a push even while popped
    assign o_ch_rdy[k]  = cnt_q != (PTR_WDTH+1)'(FIFO_DEPTH);
    assign o_sch_req[k] = cnt_q != '0;
    assign push[k]      = i_ch_vld[k] & o_ch_rdy[k];
    assign pop[k]       = legal & (i_gnt_idx == IDX_WDTH'(k));
    assign cnt_d        = cnt_q + (PTR_WDTH+1)'(push[k]) - (PTR_WDTH+1)'(pop[k]);
    assign head[k*DATA_WDTH +: DATA_WDTH] = mem_q[rp_q];
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt_q <= '0;
        wp_q  <= '0;
        rp_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        wp_q  <= push[k] ? wp_q + 1'b1 : wp_q;
        rp_q  <= pop[k] ? rp_q + 1'b1 : rp_q;
      end
    end
    // storage needs no reset: contents are only visible through a non-zero count
    always_ff @(posedge i_clk) begin
      if (push[k]) mem_q[wp_q] <= i_ch_data[k*DATA_WDTH +: DATA_WDTH];
    end
  end
  always_comb begin
    vld_d  = legal | (vld_q & ~i_rdy);
    data_d = legal ? head[i_gnt_idx*DATA_WDTH +: DATA_WDTH] : data_q;
    idx_d  = legal ? i_gnt_idx : idx_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      idx_q  <= idx_d;
    end
  end
  assign o_vld    = vld_q;
  assign o_data   = data_q;
  assign o_ch_idx = idx_q;
`ifdef CMIP_DISP_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_q | (i_gnt_vld & ~legal);
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_cmip_req_dispatch.sv
// tb_cmip_req_dispatch: randomized scoreboard bench for cmip_req_dispatch against a queue-based model
module tb_cmip_req_dispatch;
  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [7:0]   i_ch_vld = '0;
  logic [255:0] i_ch_data = '0;
  logic         i_gnt_vld = 1'b0;
  logic [2:0]   i_gnt_idx = '0;
  logic         i_rdy = 1'b0;
  logic [7:0]   o_ch_rdy, o_sch_req;
  logic         o_sch_rdy, o_vld, o_err;
  logic [31:0]  o_data;
  logic [2:0]   o_ch_idx;

  cmip_req_dispatch dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ch_vld(i_ch_vld), .i_ch_data(i_ch_data),
    .o_ch_rdy(o_ch_rdy), .o_sch_req(o_sch_req), .o_sch_rdy(o_sch_rdy),
    .i_gnt_vld(i_gnt_vld), .i_gnt_idx(i_gnt_idx), .o_vld(o_vld), .o_data(o_data),
    .o_ch_idx(o_ch_idx), .i_rdy(i_rdy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mq [8][$];
  logic [34:0] expq [$];
  bit          slot = 1'b0;
  bit          err_m = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // monitor: every accepted output word must match the oldest outstanding grant
  always @(negedge i_clk) begin
    if (!i_rst && o_vld && i_rdy) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out got idx=%0d data=%h want none", o_ch_idx, o_data);
      end else begin
        logic [34:0] e;
        e = expq.pop_front();
        chk("out_data", o_data, e[31:0]);
        chk("out_idx", o_ch_idx, e[34:32]);
      end
    end
  end

  function automatic logic [255:0] put(input int ch, input logic [31:0] w);
    logic [255:0] d;
    d = '0;
    d[ch*32 +: 32] = w;
    return d;
  endfunction

  function automatic logic [2:0] pick();
    int ne [$];
    for (int k = 0; k < 8; k++) if (mq[k].size() != 0) ne.push_back(k);
    if (ne.size() == 0) return 3'($urandom_range(7));
    return 3'(ne[$urandom_range(ne.size()-1)]);
  endfunction

  // one clock: check registered outputs, drive inputs, check o_sch_rdy, advance model, step
  task automatic cycle(input logic [7:0] v, input logic [255:0] d, input logic gv,
                       input logic [2:0] gi, input logic r);
    logic [7:0] req_m, rdy_m;
    bit legal;
    for (int k = 0; k < 8; k++) begin
      req_m[k] = mq[k].size() != 0;
      rdy_m[k] = mq[k].size() != 4;
    end
    chk("sch_req", o_sch_req, req_m);
    chk("ch_rdy", o_ch_rdy, rdy_m);
    chk("vld", o_vld, slot);
    chk("err", o_err, err_m);
    i_ch_vld = v; i_ch_data = d; i_gnt_vld = gv; i_gnt_idx = gi; i_rdy = r;
    #1;
    chk("sch_rdy", o_sch_rdy, !slot || r);
    legal = gv && (!slot || r) && mq[gi].size() != 0;
    if (legal) begin
      expq.push_back({gi, mq[gi].pop_front()});
      slot = 1'b1;
    end else if (r) slot = 1'b0;
`ifdef CMIP_DISP_ERR_CHK_EN
    if (gv && !legal) err_m = 1'b1;
`endif
    for (int k = 0; k < 8; k++) if (v[k] && rdy_m[k]) mq[k].push_back(d[k*32 +: 32]);
    @(posedge i_clk); #1;
  endtask

  task automatic reset_mid();
    i_rst = 1'b1;
    i_ch_vld = '0; i_gnt_vld = 1'b0; i_rdy = 1'b0;
    #1;
    chk("rst_vld", o_vld, 1'b0);
    chk("rst_req", o_sch_req, 8'h00);
    chk("rst_chrdy", o_ch_rdy, 8'hFF);
    chk("rst_err", o_err, 1'b0);
    chk("rst_schrdy", o_sch_rdy, 1'b1);
    for (int k = 0; k < 8; k++) mq[k].delete();
    expq.delete();
    slot = 1'b0;
    err_m = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  initial begin
    @(posedge i_clk); #1;
    reset_mid();
    // single word on ch3
    cycle(8'h08, put(3, 32'hA5A5_0003), 1'b0, 3'd0, 1'b1);
    chk("t2_req", o_sch_req, 8'h08);
    cycle(8'h00, '0, 1'b1, 3'd3, 1'b1);
    chk("t2_vld", o_vld, 1'b1);
    chk("t2_data", o_data, 32'hA5A5_0003);
    chk("t2_idx", o_ch_idx, 3'd3);
    chk("t2_req0", o_sch_req, 8'h00);
    // fill ch0 past capacity, then drain in order
    for (int i = 0; i < 5; i++) cycle(8'h01, put(0, 32'(i)), 1'b0, 3'd0, 1'b1);
    chk("t3_full", o_ch_rdy[0], 1'b0);
    cycle(8'h00, '0, 1'b1, 3'd0, 1'b1);
    chk("t3_rdy_back", o_ch_rdy[0], 1'b1);
    for (int i = 0; i < 3; i++) cycle(8'h00, '0, 1'b1, 3'd0, 1'b1);
    // backpressure on ch1
    cycle(8'h02, put(1, 32'h1111_0001), 1'b0, 3'd0, 1'b1);
    cycle(8'h02, put(1, 32'h1111_0002), 1'b1, 3'd1, 1'b1);
    cycle(8'h00, '0, 1'b1, 3'd1, 1'b0);
    chk("t4_stable", o_data, 32'h1111_0001);
    cycle(8'h00, '0, 1'b1, 3'd1, 1'b1);
    chk("t4_nobubble", o_data, 32'h1111_0002);
    cycle(8'h00, '0, 1'b0, 3'd0, 1'b1);
    // round-robin order across ch0,2,5
    for (int i = 0; i < 2; i++)
      cycle(8'h25, put(0, 32'h100 + i) | put(2, 32'h200 + i) | put(5, 32'h500 + i), 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] rr [3];
      rr = '{3'd0, 3'd2, 3'd5};
      cycle(8'h00, '0, 1'b1, rr[i % 3], 1'b1);
      chk("t5_order", o_ch_idx, rr[i % 3]);
    end
    // illegal grant to empty ch6
    cycle(8'h00, '0, 1'b0, 3'd0, 1'b1);
    cycle(8'h00, '0, 1'b1, 3'd6, 1'b1);
    chk("t6_novld", o_vld, 1'b0);
`ifdef CMIP_DISP_ERR_CHK_EN
    chk("t6_err", o_err, 1'b1);
`else
    chk("t6_err", o_err, 1'b0);
`endif
    // random traffic with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      logic [255:0] d;
      logic [2:0] gi;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      gi = ($urandom_range(3) != 0) ? pick() : 3'($urandom_range(7));
      if (i == 1500) reset_mid();
      cycle(8'($urandom), d, $urandom_range(4) != 0, gi, $urandom_range(3) != 0);
    end
    for (int i = 0; i < 40; i++) cycle(8'h00, '0, 1'b1, pick(), 1'b1);
    for (int i = 0; i < 3; i++) cycle(8'h00, '0, 1'b0, 3'd0, 1'b1);
    chk("drain_left", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
